// File: rtl/tube_pkg.sv
// Shared Tube definitions: register-3 FIFO sizing and Gray-code helpers.
package tube_pkg;

  localparam int unsigned TUBE_R3_DEPTH = 2;
  localparam int unsigned TUBE_R3_PTR_W = 2;

  typedef logic [TUBE_R3_PTR_W-1:0] r3_cnt_t;

  function automatic r3_cnt_t bin2gray(input r3_cnt_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic r3_cnt_t gray2bin(input r3_cnt_t gray);
    r3_cnt_t bin;
    bin = '0;
    bin[TUBE_R3_PTR_W-1] = gray[TUBE_R3_PTR_W-1];
    for (int i = TUBE_R3_PTR_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Width-parameterised two-flop synchroniser; NEG_EDGE selects the capturing clock edge.
module sync_2ff #(
  parameter int unsigned W        = 1,
  parameter bit          NEG_EDGE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  generate
    if (NEG_EDGE) begin : g_neg
      always_ff @(negedge clk or negedge rst_b) begin
        if (!rst_b) begin
          meta_q <= '0;
          sync_q <= '0;
        end else begin
          meta_q <= d_i;
          sync_q <= meta_q;
        end
      end
    end else begin : g_pos
      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          meta_q <= '0;
          sync_q <= '0;
        end else begin
          meta_q <= d_i;
          sync_q <= meta_q;
        end
      end
    end
  endgenerate

  assign q_o = sync_q;

endmodule

// File: rtl/hp_reg3_fifo.sv
// Host-to-parasite two-entry byte FIFO for Tube register 3, Gray-coded occupancy crossing.
// Optional parasite NMI output enabled by defining HP_REG3_NMI_EN.
module hp_reg3_fifo
  import tube_pkg::*;
#(
  parameter logic [7:0] RST_DATA = 8'h00
) (
  input  logic       h_phi2,
  input  logic       p_clk,
  input  logic       h_rst_b,
  input  logic [7:0] h_data,
  input  logic       h_selectData,
  input  logic       h_rdnw,
  input  logic       two_byte_mode,
  input  logic       p_selectData,
  input  logic       p_rd,
`ifdef HP_REG3_NMI_EN
  output logic       p_nmi_b,
`endif
  output logic [7:0] p_data,
  output logic       p_data_available,
  output logic       h_full
);

  logic [1:0] h_rst_q;
  logic [1:0] p_rst_q;
  logic       h_rst_sync_b;
  logic       p_rst_sync_b;

  logic [7:0] mem_q [TUBE_R3_DEPTH];
  r3_cnt_t    wc_q, wc_d, wg_q, rg_sync;
  r3_cnt_t    rc_q, rc_d, rg_q, wg_sync;
  r3_cnt_t    h_occ, p_occ, cap;
  logic       h_wr, push, pop;

  // Reset asserts asynchronously, releases on each domain's own active edge
  always_ff @(negedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) h_rst_q <= '0;
    else          h_rst_q <= {h_rst_q[0], 1'b1};
  end

  always_ff @(posedge p_clk or negedge h_rst_b) begin
    if (!h_rst_b) p_rst_q <= '0;
    else          p_rst_q <= {p_rst_q[0], 1'b1};
  end

  assign h_rst_sync_b = h_rst_q[1];
  assign p_rst_sync_b = p_rst_q[1];

  // Host domain: write count, registered Gray copy and storage
  assign cap    = two_byte_mode ? r3_cnt_t'(TUBE_R3_DEPTH) : r3_cnt_t'(1);
  assign h_occ  = wc_q - gray2bin(rg_sync);
  assign h_full = (h_occ >= cap);
  assign h_wr   = h_selectData & ~h_rdnw;
  assign push   = h_wr & ~h_full;

  always_comb begin
    wc_d = wc_q;
    if (push) wc_d = wc_q + r3_cnt_t'(1);
  end

  always_ff @(negedge h_phi2 or negedge h_rst_sync_b) begin
    if (!h_rst_sync_b) begin
      wc_q <= '0;
      wg_q <= '0;
      for (int i = 0; i < int'(TUBE_R3_DEPTH); i++) mem_q[i] <= RST_DATA;
    end else begin
      wc_q <= wc_d;
      wg_q <= bin2gray(wc_d);
      if (push) mem_q[wc_q[0]] <= h_data;
    end
  end

  sync_2ff #(.W(TUBE_R3_PTR_W), .NEG_EDGE(1'b0)) u_sync_wg (
    .clk   (p_clk),
    .rst_b (p_rst_sync_b),
    .d_i   (wg_q),
    .q_o   (wg_sync)
  );

  sync_2ff #(.W(TUBE_R3_PTR_W), .NEG_EDGE(1'b1)) u_sync_rg (
    .clk   (h_phi2),
    .rst_b (h_rst_sync_b),
    .d_i   (rg_q),
    .q_o   (rg_sync)
  );

  // Parasite domain: pop is gated by raw occupancy, not by the mode-qualified flag
  assign p_occ            = gray2bin(wg_sync) - rc_q;
  assign pop              = p_selectData & p_rd & (p_occ != '0);
  assign p_data_available = two_byte_mode ? (p_occ == r3_cnt_t'(TUBE_R3_DEPTH))
                                          : (p_occ != '0);
  assign p_data           = mem_q[rc_q[0]];

  always_comb begin
    rc_d = rc_q;
    if (pop) rc_d = rc_q + r3_cnt_t'(1);
  end

  always_ff @(posedge p_clk or negedge p_rst_sync_b) begin
    if (!p_rst_sync_b) begin
      rc_q <= '0;
      rg_q <= '0;
    end else begin
      rc_q <= rc_d;
      rg_q <= bin2gray(rc_d);
    end
  end

`ifdef HP_REG3_NMI_EN
  logic p_nmi_q;

  always_ff @(posedge p_clk or negedge p_rst_sync_b) begin
    if (!p_rst_sync_b) p_nmi_q <= 1'b1;
    else               p_nmi_q <= ~p_data_available;
  end

  assign p_nmi_b = p_nmi_q;
`endif

endmodule
